// File: rtl/esc_i2c_reg_bank_if.sv
// Register-access bus between the I2C slave and the ESC register bank.
interface esc_i2c_reg_bank_if;
   logic       i2c_wr;
   logic       i2c_rd;
   logic [7:0] i2c_index;
   logic [7:0] i2c_wdata;
   logic [7:0] i2c_rdata;

   modport master (
      output i2c_wr, i2c_rd, i2c_index, i2c_wdata,
      input  i2c_rdata
   );

   modport slave (
      input  i2c_wr, i2c_rd, i2c_index, i2c_wdata,
      output i2c_rdata
   );
endinterface

// File: rtl/esc_i2c_reg_bank.sv
// ESC motor command register bank: CTRL/duty/divider/watchdog/scratch registers,
// read-only status, speed snapshot and ID, behind the I2C slave strobes.
module esc_i2c_reg_bank #(
   parameter logic [7:0]  ID_VALUE   = 8'hA5,
   parameter int unsigned WDOG_PRESC = 16,
   parameter logic [15:0] DIV_RESET  = 16'd1000
) (
   input  logic                    clk,
   input  logic                    rst,
   esc_i2c_reg_bank_if.slave       bus,
   input  logic                    fault,
   input  logic [15:0]             speed,
   output logic                    motor_en,
   output logic                    motor_dir,
   output logic                    brake,
   output logic [9:0]              duty,
   output logic [15:0]             pwm_div,
   output logic                    wdog_timeout,
   output logic                    fault_latched
);

   logic                  wr_q;
   logic                  rd_q;
   logic                  wr_edge;
   logic                  rd_edge;
   logic [9:0]            duty_r;
   logic [7:0]            duty_l;
   logic [7:0]            div_l;
   logic [7:0]            wdog_cfg;
   logic [7:0]            wdog_cnt;
   logic [7:0]            scratch [10];
   logic [7:0]            snap;
   logic [7:0]            rdata_r;
   logic [7:0]            rd_mux;
   logic [WDOG_PRESC-1:0] presc;
   logic                  tick;
   logic                  in_scratch;
   logic [3:0]            sidx;
   logic                  ctrl_wr;
   logic                  wdog_hit;
   logic                  timeout_nx;
   logic                  fault_nx;
   logic                  en_nx;
   logic [15:0]           div_commit;

   assign wr_edge    = bus.i2c_wr & ~wr_q;
   assign rd_edge    = bus.i2c_rd & ~rd_q;
   assign tick       = &presc;
   assign in_scratch = (bus.i2c_index[7:4] == 4'h4) && (bus.i2c_index[3:0] >= 4'h6);
   assign sidx       = bus.i2c_index[3:0] - 4'h6;
   assign ctrl_wr    = wr_edge && (bus.i2c_index == 8'h40);
   // An accepted write reloads the counter, so it also masks expiry that cycle.
   assign wdog_hit   = (wdog_cfg != '0) && (wdog_cnt == wdog_cfg) && !wr_edge;
   assign div_commit = {bus.i2c_wdata, div_l};
   assign duty       = brake ? '0 : duty_r;
   assign bus.i2c_rdata = rdata_r;

   // Flag/enable resolution: CTRL clears first, then en, then watchdog and fault override.
   always_comb begin
      timeout_nx = wdog_timeout;
      fault_nx   = fault_latched;
      en_nx      = motor_en;
      if (ctrl_wr) begin
         if (bus.i2c_wdata[7]) timeout_nx = 1'b0;
         if (bus.i2c_wdata[6] && !fault) fault_nx = 1'b0;
         en_nx = bus.i2c_wdata[0] && !timeout_nx && !fault_nx;
      end
      if (wdog_hit) begin
         timeout_nx = 1'b1;
         en_nx      = 1'b0;
      end
      if (fault) begin
         fault_nx = 1'b1;
         en_nx    = 1'b0;
      end
   end

   // Read mux from the current index.
   always_comb begin
      rd_mux = '0;
      if (in_scratch) begin
         rd_mux = scratch[sidx];
      end else begin
         case (bus.i2c_index)
            8'h40:   rd_mux = {5'b0, brake, motor_dir, motor_en};
            8'h41:   rd_mux = duty_l;
            8'h42:   rd_mux = {6'b0, duty_r[9:8]};
            8'h43:   rd_mux = div_l;
            8'h44:   rd_mux = pwm_div[15:8];
            8'h45:   rd_mux = wdog_cfg;
            8'h50:   rd_mux = {5'b0, motor_en, fault_latched, wdog_timeout};
            8'h51:   rd_mux = speed[7:0];
            8'h52:   rd_mux = snap;
            8'h53:   rd_mux = ID_VALUE;
            default: rd_mux = '0;
         endcase
      end
   end

   // Strobe edge detectors, read data register and speed snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= 1'b1;
         rd_q    <= 1'b1;
         rdata_r <= '0;
         snap    <= '0;
      end else begin
         wr_q    <= bus.i2c_wr;
         rd_q    <= bus.i2c_rd;
         rdata_r <= rd_mux;
         if (rd_edge && (bus.i2c_index == 8'h51)) snap <= speed[15:8];
      end
   end

   // Watchdog prescaler and tick counter; counter holds once it reaches the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         wdog_cnt <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (wr_edge)
            wdog_cnt <= '0;
         else if (tick && (wdog_cfg != '0) && (wdog_cnt != wdog_cfg))
            wdog_cnt <= wdog_cnt + 8'd1;
      end
   end

   // Command registers and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         motor_en      <= 1'b0;
         motor_dir     <= 1'b0;
         brake         <= 1'b1;
         duty_r        <= '0;
         duty_l        <= '0;
         div_l         <= '0;
         pwm_div       <= DIV_RESET;
         wdog_cfg      <= 8'd100;
         wdog_timeout  <= 1'b0;
         fault_latched <= 1'b0;
         for (int unsigned i = 0; i < 10; i++) scratch[i] <= '0;
      end else begin
         motor_en      <= en_nx;
         wdog_timeout  <= timeout_nx;
         fault_latched <= fault_nx;
         if (wr_edge) begin
            if (in_scratch) begin
               scratch[sidx] <= bus.i2c_wdata;
            end else begin
               case (bus.i2c_index)
                  8'h40: begin
                     motor_dir <= bus.i2c_wdata[1];
                     brake     <= bus.i2c_wdata[2];
                  end
                  8'h41: duty_l   <= bus.i2c_wdata;
                  8'h42: duty_r   <= {bus.i2c_wdata[1:0], duty_l};
                  8'h43: div_l    <= bus.i2c_wdata;
                  8'h44: pwm_div  <= (div_commit == '0) ? 16'd1 : div_commit;
                  8'h45: wdog_cfg <= bus.i2c_wdata;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
